decade_chain_ctrl: RTL and testbench

Run-control sequencer for a chain of NUM_DIGITS counter_0_to_9 decade counters, forming a multi-digit BCD stopwatch/event counter.
- Generates a prescaled count tick and per-digit enables with ripple-carry gating.
- Also generates a synchronous clear to the counters and captures lap snapshots.
- Sits between user push-button pulses (already debounced and one-cycle) and the counter datapath.

---
 rtl/decade_chain_pkg.sv | 18 +
 rtl/counter_0_to_9.sv | 20 ++
 rtl/tick_prescaler.sv | 28 ++
 rtl/decade_chain_ctrl.sv | 127 ++++++++++++
 tb/tb_decade_chain_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decade_chain_pkg.sv
// Shared types and constants for the decade-counter chain controller.
// Pure declarations; no timing or flow control of its own.
package decade_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic is_max(input logic [3:0] d);
    return d == DIGIT_MAX;
  endfunction

endpackage

// File: rtl/counter_0_to_9.sv
// Single BCD decade counter, 0..9 with wrap, advancing on en.
// One-cycle update latency; synchronous reset has priority over en.
module counter_0_to_9
  import decade_chain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (en) begin
      q <= is_max(q) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// Divides RUN time into count ticks, one every PRESCALE enabled cycles.
// tick is combinational from the count register; the count holds while en is low.
module tick_prescaler #(
  parameter int PRESCALE = 10,
  localparam int PS_W = $clog2(PRESCALE) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ps <= '0;
    end else if (en) begin
      ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
    end
  end

  assign tick = en && (ps == PS_LAST);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run-control FSM for a chain of decade counters: prescaled tick, ripple-carry enables, clear, lap capture.
// Enables are combinational in the tick cycle; state, flags and lap capture update one edge after the pulse.
module decade_chain_ctrl
  import decade_chain_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic [4*NUM_DIGITS-1:0] digit_cnt,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    digit_rst,
  output logic                    running,
  output logic                    overflow,
  output logic                    lap_valid,
  output logic [4*NUM_DIGITS-1:0] lap_value,
  output logic [1:0]              state
);

  state_t                st;
  logic                  run_st;
  logic                  ps_clr;
  logic                  ps_tick;
  logic                  tick;
  logic                  clr_q;
  logic                  all_max;
  logic [NUM_DIGITS-1:0] nine;

  assign run_st = (st == ST_RUN);
  assign ps_clr = clear || ((st == ST_IDLE) && start);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_st),
    .clr  (ps_clr),
    .tick (ps_tick)
  );

  // A stop, clear or reset landing in the tick cycle swallows that tick.
  assign tick = ps_tick && !stop && !clear && !rst;

  always_comb begin
    nine = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nine[i] = is_max(digit_cnt[4*i +: 4]);
    end
  end

  assign all_max = &nine;

  // Ripple carry: digit i advances only when every lower digit is about to wrap.
  always_comb begin
    logic carry;
    carry    = tick;
    digit_en = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_en[i] = carry;
      carry       = carry && nine[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      running   <= 1'b0;
      overflow  <= 1'b0;
      clr_q     <= 1'b0;
      lap_valid <= 1'b0;
      lap_value <= '0;
    end else begin
      clr_q     <= clear;
      lap_valid <= 1'b0;
      if (lap && !clear && (st != ST_IDLE)) begin
        lap_valid <= 1'b1;
        lap_value <= digit_cnt;
      end
      if (clear) begin
        st       <= ST_IDLE;
        running  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (start) begin
              st      <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              st      <= ST_PAUSE;
              running <= 1'b0;
            end else if (tick && all_max) begin
              // Counters wrap to zero on this same edge; the chain then stays halted.
              st       <= ST_OVF;
              running  <= 1'b0;
              overflow <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              st      <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_OVF: begin
            st <= ST_OVF;
          end
          default: begin
            st      <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digit_rst = rst || clr_q;
  assign state     = st;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl: scoreboarded random/directed run on a 2-digit, /3 chain
// plus a short directed pass on a 1-digit, undivided chain.
module tb_decade_chain_ctrl;

  localparam int N    = 2;
  localparam int P    = 3;
  localparam int MODV = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [4*N-1:0] digit_cnt;
  logic [N-1:0]   digit_en;
  logic           digit_rst, running, overflow, lap_valid;
  logic [4*N-1:0] lap_value;
  logic [1:0]     state;

  logic       b_rst = 1'b1;
  logic       b_start = 1'b0, b_stop = 1'b0, b_clear = 1'b0, b_lap = 1'b0;
  logic [3:0] b_cnt;
  logic [0:0] b_en;
  logic       b_drst, b_running, b_ovf, b_lapv;
  logic [3:0] b_lapval;
  logic [1:0] b_state;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digit_cnt(digit_cnt), .digit_en(digit_en), .digit_rst(digit_rst),
    .running(running), .overflow(overflow), .lap_valid(lap_valid),
    .lap_value(lap_value), .state(state)
  );

  for (genvar g = 0; g < N; g++) begin : g_cnt
    counter_0_to_9 u_cnt (.clk(clk), .rst(digit_rst), .en(digit_en[g]), .q(digit_cnt[4*g +: 4]));
  end

  decade_chain_ctrl #(.NUM_DIGITS(1), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .clear(b_clear), .lap(b_lap),
    .digit_cnt(b_cnt), .digit_en(b_en), .digit_rst(b_drst),
    .running(b_running), .overflow(b_ovf), .lap_valid(b_lapv),
    .lap_value(b_lapval), .state(b_state)
  );

  counter_0_to_9 u_cnt_b (.clk(clk), .rst(b_drst), .en(b_en[0]), .q(b_cnt));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole chain is one integer count modulo 10^N.
  int m_state = 0;
  int m_phase = 0;
  int m_count = 0;
  bit m_ovf   = 1'b0;
  bit m_clrq  = 1'b0;

  typedef struct {
    logic [N-1:0] pat;
    int           nxt;
  } tick_t;

  tick_t          tick_q[$];
  logic [4*N-1:0] lap_q[$];
  bit             mon_on = 1'b0;

  function automatic logic [4*N-1:0] bcd(input int v);
    logic [4*N-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit i advances when the value below it is all nines.
  function automatic logic [N-1:0] pat(input int v);
    logic [N-1:0] r;
    int p10;
    r   = '0;
    p10 = 1;
    for (int i = 0; i < N; i++) begin
      r[i] = ((v % p10) == (p10 - 1));
      p10  = p10 * 10;
    end
    return r;
  endfunction

  task automatic cyc(input bit s, input bit p, input bit c, input bit l, input bit r);
    bit    tk;
    tick_t it;
    int    n_count;
    @(negedge clk);
    #1;
    check("state", state, m_state);
    check("running", running, (m_state == 1));
    check("overflow", overflow, m_ovf);
    check("count", digit_cnt, bcd(m_count));
    rst = r; start = s; stop = p; clear = c; lap = l;
    tk = !r && (m_state == 1) && (m_phase == P - 1) && !p && !c;
    if (tk) begin
      it.pat = pat(m_count);
      it.nxt = (m_count + 1) % MODV;
      tick_q.push_back(it);
    end
    if (l && !c && !r && (m_state != 0)) lap_q.push_back(bcd(m_count));
    #1;
    check("digit_rst", digit_rst, (r || m_clrq));
    if (r) begin
      m_state = 0; m_phase = 0; m_count = 0; m_ovf = 1'b0; m_clrq = 1'b0;
    end else begin
      n_count = m_clrq ? 0 : (tk ? (m_count + 1) % MODV : m_count);
      if (c) m_phase = 0;
      else if (m_state == 1) m_phase = (m_phase + 1) % P;
      if (c) begin
        m_state = 0;
        m_ovf   = 1'b0;
      end else begin
        case (m_state)
          0: if (s) m_state = 1;
          1: begin
            if (p) m_state = 2;
            else if (tk && (m_count == MODV - 1)) begin
              m_state = 3;
              m_ovf   = 1'b1;
            end
          end
          2: if (s) m_state = 1;
          default: m_state = 3;
        endcase
      end
      m_count = n_count;
      m_clrq  = c;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: pops an expectation whenever the DUT presents enables or a lap pulse.
  initial begin
    tick_t it;
    int    pend_val;
    bit    pend;
    pend = 1'b0;
    pend_val = 0;
    forever begin
      @(negedge clk);
      #3;
      if (mon_on) begin
        if (pend) begin
          check("tick_count", digit_cnt, bcd(pend_val));
          pend = 1'b0;
        end
        if (digit_en !== '0) begin
          if (tick_q.size() == 0) begin
            check("unexpected_digit_en", digit_en, '0);
          end else begin
            it = tick_q.pop_front();
            check("digit_en", digit_en, it.pat);
            pend_val = it.nxt;
            pend     = 1'b1;
          end
        end
        if (lap_valid === 1'b1) begin
          if (lap_q.size() == 0) check("unexpected_lap_valid", lap_valid, 1'b0);
          else check("lap_value", lap_value, lap_q.pop_front());
        end else if (lap_valid !== 1'b0) begin
          check("lap_valid_known", lap_valid, 1'b0);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_digit_en", digit_en, '0);
    check("reset_digit_rst", digit_rst, 1'b1);
    check("reset_lap_valid", lap_valid, 1'b0);
    check("reset_lap_value", lap_value, '0);
    mon_on = 1'b1;
    cyc(0, 0, 0, 0, 1);
    idle(2);

    // Counting from zero through the first carry.
    cyc(1, 0, 0, 0, 0);
    idle(40);
    // Run on to full scale and wrap into OVF; start is ignored there.
    idle(280);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    idle(3);
    // Pause mid-prescale, hold, then resume.
    cyc(1, 0, 0, 0, 0);
    idle(22);
    cyc(0, 1, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 0, 0);
    idle(6);
    // Clear while running, then clear and start together.
    idle(100);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0, 0);
    idle(2);
    // Laps: in RUN, back-to-back, in IDLE, and coincident with clear.
    cyc(1, 0, 0, 0, 0);
    idle(104);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle(3);
    // Reset in the middle of a run.
    cyc(1, 0, 0, 0, 0);
    idle(8);
    cyc(0, 0, 0, 0, 1);
    idle(2);

    for (int k = 0; k < 4000; k++) begin
      if (k < 2000)
        cyc($urandom_range(0, 999) < 200, $urandom_range(0, 999) < 80,
            $urandom_range(0, 999) < 25, $urandom_range(0, 999) < 100,
            $urandom_range(0, 999) < 8);
      else
        cyc($urandom_range(0, 999) < 40, $urandom_range(0, 999) < 8,
            $urandom_range(0, 999) < 3, $urandom_range(0, 999) < 30,
            $urandom_range(0, 999) < 1);
    end
    idle(4);
    check("tick_queue_drained", tick_q.size(), 0);
    check("lap_queue_drained", lap_q.size(), 0);

    // Single digit, tick every RUN cycle.
    @(negedge clk);
    #1;
    check("b_reset_state", b_state, 2'd0);
    check("b_reset_cnt", b_cnt, 4'd0);
    check("b_reset_digit_rst", b_drst, 1'b1);
    check("b_reset_en", b_en, 1'b0);
    b_rst = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    #1;
    b_start = 1'b0;
    check("b_run_state", b_state, 2'd1);
    check("b_run_cnt0", b_cnt, 4'd0);
    repeat (6) @(negedge clk);
    #1;
    check("b_cnt6", b_cnt, 4'd6);
    check("b_tick_en", b_en, 1'b1);
    b_stop = 1'b1;
    #1;
    check("b_stop_suppress_en", b_en, 1'b0);
    @(negedge clk);
    #1;
    b_stop = 1'b0;
    check("b_pause_cnt", b_cnt, 4'd6);
    check("b_pause_state", b_state, 2'd2);
    b_start = 1'b1;
    @(negedge clk);
    #1;
    b_start = 1'b0;
    check("b_resume_state", b_state, 2'd1);
    check("b_resume_cnt", b_cnt, 4'd6);
    b_rst = 1'b1;
    #1;
    check("b_rst_en", b_en, 1'b0);
    check("b_rst_digit_rst", b_drst, 1'b1);
    @(negedge clk);
    #1;
    b_rst = 1'b0;
    check("b_after_rst_state", b_state, 2'd0);
    check("b_after_rst_cnt", b_cnt, 4'd0);
    check("b_after_rst_running", b_running, 1'b0);
    b_start = 1'b1;
    @(negedge clk);
    #1;
    b_start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("b_cnt9", b_cnt, 4'd9);
    @(negedge clk);
    #1;
    check("b_ovf_state", b_state, 2'd3);
    check("b_ovf_flag", b_ovf, 1'b1);
    check("b_ovf_wrap", b_cnt, 4'd0);
    check("b_ovf_en", b_en, 1'b0);
    check("b_no_lap", b_lapv, 1'b0);
    check("b_lap_value", b_lapval, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
